// File: rtl/stream_to_rs232.sv
// stream_to_rs232: RS-232 8N1 transmitter with CTS flow control.
// Bytes arrive on a valid/ready stream and leave LSB-first on txd_pin.
// Bit timing comes from a fractional accumulator, so non-integer
// CLOCK_FREQ/BAUD_RATE ratios keep the exact average rate. The
// accumulator error stays below one clock period.
// CLOCK_FREQ must be at least 2*BAUD_RATE. STOP_BITS must be 1 or 2.
module stream_to_rs232 #(
    parameter int unsigned CLOCK_FREQ = 133000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd_pin,
    input  logic       ctsn_pin,
    output logic       obusy
);

    // 33 bits: acc + BAUD_RATE cannot overflow for any 32-bit CLOCK_FREQ
    localparam int unsigned ACC_W  = 33;
    localparam int unsigned STOP_W = 1;

    localparam logic [ACC_W-1:0]  BAUD_INC  = ACC_W'(BAUD_RATE);
    localparam logic [ACC_W-1:0]  CLK_DIV   = ACC_W'(CLOCK_FREQ);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [7:0]        shift, shift_next;
    logic [2:0]        bitcnt, bitcnt_next;
    logic [STOP_W-1:0] stopcnt, stopcnt_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic              txd_next;
    logic              obusy_next;

    logic              ctsn_q1, ctsn_q2;
    logic              cts_sync;

    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_wrap;
    logic              tick;

    // Two-flop synchroniser for the asynchronous CTS pin; resets to "not clear"
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctsn_q1 <= 1'b1;
            ctsn_q2 <= 1'b1;
        end else begin
            ctsn_q1 <= ctsn_pin;
            ctsn_q2 <= ctsn_q1;
        end
    end

    assign cts_sync = ~ctsn_q2;

    // Ready is a pure function of registers, never of ivalid
    assign iready = (state == IDLE) && cts_sync;

    // Baud tick fires when the accumulator crosses one clock-frequency unit
    assign acc_sum  = acc + BAUD_INC;
    assign acc_wrap = acc_sum - CLK_DIV;
    assign tick     = (acc_sum >= CLK_DIV);

    // Frame state and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            shift   <= '0;
            bitcnt  <= '0;
            stopcnt <= '0;
            acc     <= '0;
            txd_pin <= 1'b1;
            obusy   <= 1'b0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bitcnt  <= bitcnt_next;
            stopcnt <= stopcnt_next;
            acc     <= acc_next;
            txd_pin <= txd_next;
            obusy   <= obusy_next;
        end
    end

    // Next-state and datapath: start bit, 8 data bits LSB-first, stop bits
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bitcnt_next  = bitcnt;
        stopcnt_next = stopcnt;
        acc_next     = acc;
        txd_next     = txd_pin;

        if (state != IDLE) begin
            acc_next = tick ? acc_wrap : acc_sum;
        end

        case (state)
            IDLE: begin
                if (ivalid && iready) begin
                    state_next  = START;
                    shift_next  = idata;
                    txd_next    = 1'b0;
                    acc_next    = '0;
                    bitcnt_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    txd_next   = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next  = shift >> 1;
                    bitcnt_next = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        txd_next     = 1'b1;
                        stopcnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        txd_next = shift[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stopcnt == LAST_STOP) begin
                        state_next = IDLE;
                    end else begin
                        stopcnt_next = stopcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        obusy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_stream_to_rs232.sv
// tb_stream_to_rs232: self-checking bench for the RS-232 transmitter.
// Three instances: 8/1 with one stop bit, 133/12 (fractional) and 8/1 with two stop bits.
// Expected line levels come from bit boundaries at ceil(n*CLOCK_FREQ/BAUD_RATE) cycles after accept.
`timescale 1ns/1ps
module tb_stream_to_rs232;

    logic            clock = 1'b0;
    logic            resetn;
    logic [2:0][7:0] idata;
    logic [2:0]      ivalid;
    logic [2:0]      ctsn;
    wire  [2:0]      iready;
    wire  [2:0]      txd;
    wire  [2:0]      obusy;

    int vectors     = 0;
    int miscompares = 0;

    // 10 ns clock
    always #5 clock = ~clock;

    stream_to_rs232 #(.CLOCK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(1)) dut_a (
        .clock(clock), .resetn(resetn), .idata(idata[0]), .ivalid(ivalid[0]),
        .iready(iready[0]), .txd_pin(txd[0]), .ctsn_pin(ctsn[0]), .obusy(obusy[0]));

    stream_to_rs232 #(.CLOCK_FREQ(133), .BAUD_RATE(12), .STOP_BITS(1)) dut_b (
        .clock(clock), .resetn(resetn), .idata(idata[1]), .ivalid(ivalid[1]),
        .iready(iready[1]), .txd_pin(txd[1]), .ctsn_pin(ctsn[1]), .obusy(obusy[1]));

    stream_to_rs232 #(.CLOCK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(2)) dut_c (
        .clock(clock), .resetn(resetn), .idata(idata[2]), .ivalid(ivalid[2]),
        .iready(iready[2]), .txd_pin(txd[2]), .ctsn_pin(ctsn[2]), .obusy(obusy[2]));

    // Reference model: per-instance line parameters
    function automatic int cf_of(input int sel);
        return (sel == 1) ? 133 : 8;
    endfunction

    function automatic int br_of(input int sel);
        return (sel == 1) ? 12 : 1;
    endfunction

    function automatic int sb_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    // Cycle (counted from the accept edge) at which line bit i ends
    function automatic int bit_end(input int sel, input int i);
        return ((i + 1) * cf_of(sel) + br_of(sel) - 1) / br_of(sel);
    endfunction

    function automatic int frame_len(input int sel);
        return bit_end(sel, 8 + sb_of(sel));
    endfunction

    // Line level c cycles after the accept edge: start 0, data LSB-first, stop 1
    function automatic logic exp_line(input int sel, input logic [7:0] b, input int c);
        for (int i = 0; i < 9 + sb_of(sel); i++) begin
            if (c < bit_end(sel, i)) begin
                if (i == 0) return 1'b0;
                if (i <= 8) return b[i-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // With ivalid set, wait for iready; returns just after the accept edge
    task automatic wait_accept(input int sel, input int max_cycles, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (iready[sel] === 1'b1) ok = 1'b1;
            step();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: iready not seen within %0d cycles (got 0, required 1)", name, max_cycles);
        end
    endtask

    // Called just after the accept edge; checks the whole frame cycle by cycle
    task automatic run_frame(input int sel, input logic [7:0] b, input logic next_valid,
                             input logic [7:0] next_byte, input logic noise,
                             input int cts_raise_c, input string name);
        int         len;
        logic [2:0] got, want;
        len = frame_len(sel);
        for (int c = 0; c < len; c++) begin
            if (c == cts_raise_c) ctsn[sel] = 1'b1;
            if (c == 0 || c == len - 1 || !noise) begin
                ivalid[sel] = next_valid;
                idata[sel]  = next_byte;
            end else begin
                ivalid[sel] = 1'($urandom_range(0, 1));
                if (!ivalid[sel]) idata[sel] = 8'($urandom);
            end
            got  = {txd[sel], obusy[sel], iready[sel]};
            want = {exp_line(sel, b, c), 1'b1, 1'b0};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s byte 0x%02h cycle %0d: txd/obusy/iready got %b required %b",
                         name, b, c, got, want);
            end
            step();
        end
        got  = {txd[sel], obusy[sel], iready[sel]};
        want = {1'b1, 1'b0, ~ctsn[sel]};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s_end byte 0x%02h: txd/obusy/iready got %b required %b", name, b, got, want);
        end
    endtask

    // Check the idle line for n cycles
    task automatic check_idle(input int sel, input int n, input logic exp_ready, input string name);
        logic [2:0] got, want;
        for (int i = 0; i < n; i++) begin
            got  = {txd[sel], obusy[sel], iready[sel]};
            want = {1'b1, 1'b0, exp_ready};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s cycle %0d: txd/obusy/iready got %b required %b", name, i, got, want);
            end
            step();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        vectors++;
        if (txd !== 3'b111) begin
            miscompares++; $display("FAIL reset_txd: got %b required 111", txd);
        end
        vectors++;
        if (obusy !== 3'b000) begin
            miscompares++; $display("FAIL reset_obusy: got %b required 000", obusy);
        end
        ivalid = 3'b111;
        #1;
        vectors++;
        if (iready !== 3'b000) begin
            miscompares++; $display("FAIL reset_iready: got %b required 000", iready);
        end
        ivalid = 3'b000;
        step();
        resetn = 1'b1;
        #1;
        vectors++;
        if (iready !== 3'b000) begin
            miscompares++; $display("FAIL release_iready0: got %b required 000", iready);
        end
        step();
        vectors++;
        if (iready !== 3'b000) begin
            miscompares++; $display("FAIL release_iready1: got %b required 000", iready);
        end
        step();
        vectors++;
        if (iready !== 3'b111) begin
            miscompares++; $display("FAIL release_iready2: got %b required 111", iready);
        end
        ivalid[0] = 1'b1;
        #1;
        vectors++;
        if (iready[0] !== 1'b1) begin
            miscompares++; $display("FAIL iready_vs_ivalid: got %b required 1", iready[0]);
        end
        ivalid[0] = 1'b0;
        step();
    endtask

    task automatic test_basic();
        idata[0]  = 8'hA5;
        ivalid[0] = 1'b1;
        wait_accept(0, 3, "basic_accept");
        run_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, -1, "basic");
        check_idle(0, 4, 1'b1, "basic_idle");
    endtask

    task automatic test_cts_hold();
        ctsn[0] = 1'b1;
        repeat (3) step();
        idata[0]  = 8'h3C;
        ivalid[0] = 1'b1;
        check_idle(0, 20, 1'b0, "cts_hold");
        ctsn[0] = 1'b0;
        wait_accept(0, 3, "cts_release_accept");
        run_frame(0, 8'h3C, 1'b0, 8'h00, 1'b0, -1, "cts_release");
    endtask

    task automatic test_back_to_back();
        idata[0]  = 8'h00;
        ivalid[0] = 1'b1;
        wait_accept(0, 3, "b2b_accept");
        run_frame(0, 8'h00, 1'b1, 8'hFF, 1'b0, -1, "b2b_00");
        step();
        run_frame(0, 8'hFF, 1'b1, 8'h55, 1'b0, -1, "b2b_ff");
        step();
        run_frame(0, 8'h55, 1'b0, 8'h00, 1'b0, -1, "b2b_55");
        check_idle(0, 10, 1'b1, "b2b_no_dup");
    endtask

    task automatic test_cts_midframe();
        idata[0]  = 8'h81;
        ivalid[0] = 1'b1;
        wait_accept(0, 3, "cts_mid_accept");
        // middle of data bit 3 (line bit 4 spans cycles 32..39)
        run_frame(0, 8'h81, 1'b1, 8'h42, 1'b0, 36, "cts_mid");
        check_idle(0, 12, 1'b0, "cts_mid_blocked");
        ctsn[0] = 1'b0;
        wait_accept(0, 3, "cts_mid_resume");
        run_frame(0, 8'h42, 1'b0, 8'h00, 1'b0, -1, "cts_mid_next");
    endtask

    task automatic test_fractional();
        idata[1]  = 8'h5A;
        ivalid[1] = 1'b1;
        wait_accept(1, 3, "frac_accept");
        run_frame(1, 8'h5A, 1'b0, 8'h00, 1'b0, -1, "frac");
    endtask

    task automatic test_reset_midframe();
        idata[0]  = 8'hC3;
        ivalid[0] = 1'b1;
        wait_accept(0, 3, "rst_mid_accept");
        ivalid[0] = 1'b0;
        repeat (50) step();
        resetn = 1'b0;
        #1;
        check_idle(0, 3, 1'b0, "rst_mid_hold");
        resetn = 1'b1;
        #1;
        check_idle(0, 2, 1'b0, "rst_mid_resync");
        check_idle(0, 5, 1'b1, "rst_mid_lost");
        idata[0]  = 8'h96;
        ivalid[0] = 1'b1;
        wait_accept(0, 3, "rst_mid_next_accept");
        run_frame(0, 8'h96, 1'b0, 8'h00, 1'b0, -1, "rst_mid_next");
    endtask

    // Random bytes, random gaps, ivalid/idata noise while the block is busy
    task automatic test_random(input int sel);
        logic [7:0] bytes[6];
        int         gaps[6];
        for (int k = 0; k < 6; k++) begin
            bytes[k] = 8'($urandom);
            gaps[k]  = $urandom_range(0, 3);
        end
        idata[sel]  = bytes[0];
        ivalid[sel] = 1'b1;
        wait_accept(sel, 3, "random_first");
        for (int k = 0; k < 6; k++) begin
            logic       nv;
            logic [7:0] nb;
            nv = (k < 5) && (gaps[k+1] == 0);
            nb = (k < 5) ? bytes[k+1] : 8'h00;
            run_frame(sel, bytes[k], nv, nb, 1'b1, -1, "random");
            if (k < 5) begin
                if (nv) begin
                    step();
                end else begin
                    check_idle(sel, gaps[k+1], 1'b1, "random_gap");
                    idata[sel]  = bytes[k+1];
                    ivalid[sel] = 1'b1;
                    wait_accept(sel, 2, "random_next");
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        ivalid = '0;
        ctsn   = '0;
        idata  = '0;
        test_reset();
        test_basic();
        test_cts_hold();
        test_back_to_back();
        test_cts_midframe();
        test_fractional();
        test_reset_midframe();
        test_random(0);
        test_random(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (%0d vectors, %0d miscompares)",
                 vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
